display_bus_receiver_8080: RTL and testbench
============================================

Name: display_bus_receiver_8080

Overview:
- Receive side of the 8-bit 8080 write bus used by our ILI9341 display controller; acts as an FPGA-side display emulator/bus monitor.
- Decodes command and parameter bytes, tracks the CASET/PASET address window, and assembles RAMWR byte pairs into 16-bit pixels.
- Emits pixels on a 16-bit AXI stream master with coordinates, start-of-frame and end-of-window flags.
- Used in loopback benches and for capturing framebuffer traffic into memory.

Parameters:
SYNC_STAGES, 2, synchronizer depth on all bus inputs (min 2)
DEFAULT_WIDTH, 320, column count of the reset window
DEFAULT_HEIGHT, 240, page count of the reset window

Ports:
aclk  in  1  clock
reset  in  1  asynchronous, active-high reset
data  in  8  8080 data bus
wr  in  1  write strobe, active low; data latched on rising edge
cs  in  1  chip select, active low
dc  in  1  0 = command byte, 1 = parameter/pixel byte
rd  in  1  ignored (write-only bus)
rst  in  1  display reset, active low
m_axis_tvalid  out  1  pixel valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  16  RGB565 pixel, first received byte in [15:8]
m_axis_tuser  out  1  first pixel of a RAMWR burst at window origin
m_axis_tlast  out  1  last pixel of window (x==xe, y==ye)
pixel_x  out  16  column of the current output pixel
pixel_y  out  16  page of the current output pixel
cmd_strobe  out  1  one-cycle pulse per command byte
cmd_code  out  8  last command byte received
overflow  out  1  sticky; a pixel was dropped

Behaviour:
- Reset (async, active-high): all outputs 0, except cmd_code=0x00. Window xs=0, xe=DEFAULT_WIDTH-1, ys=0, ye=DEFAULT_HEIGHT-1. FSM=IDLE, byte phase=0.
- Input conditioning: wr, cs, dc, data and rst each pass through SYNC_STAGES flops.
- Byte event: synchronized wr goes 0->1 while synchronized cs=0. The byte and dc are taken from the same synchronized stage as wr.
- Bus timing: wr low >= 1 aclk and wr high >= 1 aclk when the transmitter is on aclk; otherwise >= 2 aclk each.
- Synchronized rst=0: FSM=IDLE, window returns to defaults, phase=0. overflow and the output register are held.
- Command byte (dc=0), accepted in any state:
  - Pulse cmd_strobe and update cmd_code the cycle after the event.
  - Any partial pixel is discarded; param counter=0.
  - Next state: 0x2A -> CASET, 0x2B -> PASET, 0x2C -> RAMWR, 0x01 -> window defaults then IDLE, all others -> SKIP.
- CASET/PASET: collect 4 parameter bytes (start_hi, start_lo, end_hi, end_lo).
  - Window registers update atomically on the 4th byte, then FSM=IDLE.
  - Extra parameter bytes are ignored until the next command.
- RAMWR:
  - On entry x=xs, y=ys, phase=0.
  - Phase 0 byte -> hi register. Phase 1 byte completes the pixel.
  - Advance: if x>=xe then x=xs and (if y>=ye then y=ys, else y+1); else x+1. Wraps indefinitely; start>end yields one pixel per row.
- SKIP/IDLE: parameter bytes are discarded.
- Output register: a completed pixel loads tdata/x/y/tuser/tlast and sets tvalid one aclk after the phase-1 event. Total latency is SYNC_STAGES+1 aclk after the physical wr rising edge.
  - tuser=1 iff x==xs and y==ys.
  - tlast=1 iff x==xe and y==ye (unsigned compare).
- Backpressure: the 8080 bus cannot be stalled.
  - If a pixel completes while tvalid=1 and tready=0, the new pixel is dropped, overflow is set, and the coordinates still advance.
  - Same-cycle tready=1 with a new pixel: the register reloads and tvalid stays 1.
- AXI: tdata/tuser/tlast/pixel_x/pixel_y are stable while tvalid=1 and tready=0.
- cs high: wr edges are ignored; FSM and phase are unchanged.
- Reset mid-burst: returns immediately to reset state; no further pixels are emitted.

Test Plan:
- Init then pixels: after reset send 0x2C, then bytes 0xF8,0x00,0x07,0xE0 -> two beats 0xF800 (x=0,y=0,tuser=1) and 0x07E0 (x=1,y=0).
- Window: CASET 00 0A 00 0B, PASET 00 05 00 06, RAMWR, 4 pixels -> coordinates (10,5),(11,5),(10,6),(11,6) with tlast only on the 4th. A 5th pixel wraps to (10,5) with tuser=1.
- Full frame: default window, 76800 pixels -> tlast only on pixel 76799 at (319,239). Pixel 76800 -> tuser=1 at (0,0).
- Abort: RAMWR, send byte 0xAB, then command 0x29 (dc=0) -> no pixel emitted, cmd_code=0x29, cmd_strobe pulses once.
- Overflow: hold tready=0 and send 2 pixels -> first pixel held stable, second dropped, overflow=1 until reset.
- cs/rst gating: wr toggles with cs=1 -> no events. Pulse rst=0 after CASET 00 10 00 20 -> window returns to 0..319.

Source files
------------

// File: rtl/display_bus_receiver_8080_if.sv
// Bundles the 8080 write bus, the pixel AXI stream and the command sideband.
// The receiver attaches through the slave modport and the bus driver through the master modport.
interface display_bus_receiver_8080_if;
  logic [7:0]  data;
  logic        wr;
  logic        cs;
  logic        dc;
  logic        rd;
  logic        rst;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic [15:0] pixel_x;
  logic [15:0] pixel_y;
  logic        cmd_strobe;
  logic [7:0]  cmd_code;
  logic        overflow;

  modport slave (
    input  data, wr, cs, dc, rd, rst, m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
           pixel_x, pixel_y, cmd_strobe, cmd_code, overflow
  );

  modport master (
    output data, wr, cs, dc, rd, rst, m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast,
           pixel_x, pixel_y, cmd_strobe, cmd_code, overflow
  );
endinterface

// File: rtl/display_bus_receiver_8080.sv
// ILI9341-style 8080 write-bus receiver: decodes commands, tracks the CASET/PASET
// window and turns RAMWR byte pairs into RGB565 pixels on an AXI stream.
module display_bus_receiver_8080 #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEFAULT_WIDTH  = 320,
  parameter int DEFAULT_HEIGHT = 240
) (
  input logic                        aclk,
  input logic                        reset,
  display_bus_receiver_8080_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_SKIP} state_e;

  localparam logic [15:0] DEF_XE = 16'(DEFAULT_WIDTH - 1);
  localparam logic [15:0] DEF_YE = 16'(DEFAULT_HEIGHT - 1);

  logic [SYNC_STAGES-1:0]      wr_sync_q, cs_sync_q, dc_sync_q, rst_sync_q;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q;
  logic                        wr_prev_q;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic [23:0] par_q, par_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic [15:0] tdata_q, tdata_d, px_q, px_d, py_q, py_d;
  logic        cmd_strobe_q, cmd_strobe_d, overflow_q, overflow_d;
  logic [7:0]  cmd_code_q, cmd_code_d;

  logic       wr_s, cs_s, dc_s, rst_s, byte_evt;
  logic [7:0] d_s;
  logic       rd_unused;

  assign rd_unused = bus.rd;
  assign wr_s      = wr_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign rst_s     = rst_sync_q[SYNC_STAGES-1];
  assign d_s       = data_sync_q[SYNC_STAGES-1];
  // Byte and dc come from the same stage as wr, so they are aligned with the edge.
  assign byte_evt  = wr_s && !wr_prev_q && !cs_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      wr_sync_q   <= '1;
      cs_sync_q   <= '1;
      dc_sync_q   <= '0;
      rst_sync_q  <= '1;
      data_sync_q <= '0;
      wr_prev_q   <= 1'b1;
    end else begin
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], bus.wr};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], bus.dc};
      rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], bus.rst};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.data};
      wr_prev_q   <= wr_s;
    end
  end

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    pcnt_d       = pcnt_q;
    par_d        = par_q;
    hi_d         = hi_q;
    xs_d         = xs_q;
    xe_d         = xe_q;
    ys_d         = ys_q;
    ye_d         = ye_q;
    x_d          = x_q;
    y_d          = y_q;
    tvalid_d     = tvalid_q && !bus.m_axis_tready;
    tdata_d      = tdata_q;
    tuser_d      = tuser_q;
    tlast_d      = tlast_q;
    px_d         = px_q;
    py_d         = py_q;
    cmd_strobe_d = 1'b0;
    cmd_code_d   = cmd_code_q;
    overflow_d   = overflow_q;

    if (!rst_s) begin
      state_d = S_IDLE;
      phase_d = 1'b0;
      pcnt_d  = '0;
      xs_d    = '0;
      xe_d    = DEF_XE;
      ys_d    = '0;
      ye_d    = DEF_YE;
    end else if (byte_evt && !dc_s) begin
      cmd_strobe_d = 1'b1;
      cmd_code_d   = d_s;
      phase_d      = 1'b0;
      pcnt_d       = '0;
      case (d_s)
        8'h2A: state_d = S_CASET;
        8'h2B: state_d = S_PASET;
        8'h2C: begin
          state_d = S_RAMWR;
          x_d     = xs_q;
          y_d     = ys_q;
        end
        8'h01: begin
          state_d = S_IDLE;
          xs_d    = '0;
          xe_d    = DEF_XE;
          ys_d    = '0;
          ye_d    = DEF_YE;
        end
        default: state_d = S_SKIP;
      endcase
    end else if (byte_evt) begin
      case (state_q)
        S_CASET, S_PASET: begin
          if (pcnt_q == 2'd3) begin
            // par_q holds start_hi, start_lo, end_hi; the window updates atomically here.
            if (state_q == S_CASET) begin
              xs_d = par_q[23:8];
              xe_d = {par_q[7:0], d_s};
            end else begin
              ys_d = par_q[23:8];
              ye_d = {par_q[7:0], d_s};
            end
            pcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            par_d  = {par_q[15:0], d_s};
            pcnt_d = pcnt_q + 2'd1;
          end
        end
        S_RAMWR: begin
          if (!phase_q) begin
            hi_d    = d_s;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (tvalid_q && !bus.m_axis_tready) begin
              overflow_d = 1'b1;
            end else begin
              tvalid_d = 1'b1;
              tdata_d  = {hi_q, d_s};
              px_d     = x_q;
              py_d     = y_q;
              tuser_d  = (x_q == xs_q) && (y_q == ys_q);
              tlast_d  = (x_q == xe_q) && (y_q == ye_q);
            end
            // Coordinates advance even when the pixel is dropped.
            if (x_q >= xe_q) begin
              x_d = xs_q;
              y_d = (y_q >= ye_q) ? ys_q : y_q + 16'd1;
            end else begin
              x_d = x_q + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      pcnt_q       <= '0;
      par_q        <= '0;
      hi_q         <= '0;
      xs_q         <= '0;
      xe_q         <= DEF_XE;
      ys_q         <= '0;
      ye_q         <= DEF_YE;
      x_q          <= '0;
      y_q          <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      cmd_strobe_q <= 1'b0;
      cmd_code_q   <= 8'h00;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pcnt_q       <= pcnt_d;
      par_q        <= par_d;
      hi_q         <= hi_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      x_q          <= x_d;
      y_q          <= y_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tuser_q      <= tuser_d;
      tlast_q      <= tlast_d;
      px_q         <= px_d;
      py_q         <= py_d;
      cmd_strobe_q <= cmd_strobe_d;
      cmd_code_q   <= cmd_code_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tuser  = tuser_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.pixel_x       = px_q;
  assign bus.pixel_y       = py_q;
  assign bus.cmd_strobe    = cmd_strobe_q;
  assign bus.cmd_code      = cmd_code_q;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_display_bus_receiver_8080.sv
// Self-checking bench: randomized 8080 traffic against a queue-based display model,
// plus directed scenarios with literal expectations.
module tb_display_bus_receiver_8080;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] x;
    logic [15:0] y;
    logic        u;
    logic        l;
  } beat_t;

  logic aclk = 1'b0;
  logic reset;
  display_bus_receiver_8080_if bus ();

  display_bus_receiver_8080 #(
    .SYNC_STAGES(2), .DEFAULT_WIDTH(320), .DEFAULT_HEIGHT(240)
  ) dut (
    .aclk (aclk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  beat_t      exp_q[$];
  beat_t      got_q[$];
  logic [7:0] cmd_q[$];

  // Display model: mode 0 idle, 1 column window, 2 page window, 3 pixel write, 4 skip.
  int          m_mode, m_pcnt, m_phase;
  logic [7:0]  m_pb[4];
  logic [7:0]  m_hi;
  logic [15:0] m_xs, m_xe, m_ys, m_ye, m_x, m_y;
  bit          m_drop_next;

  bit hold_ready = 1'b0;
  int stall_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_defaults();
    m_xs = 16'd0; m_xe = 16'd319; m_ys = 16'd0; m_ye = 16'd239;
  endfunction

  function automatic void model_reset();
    model_defaults();
    m_mode = 0; m_pcnt = 0; m_phase = 0; m_drop_next = 1'b0;
  endfunction

  function automatic void model_byte(input bit dc, input logic [7:0] d);
    beat_t b;
    if (!dc) begin
      cmd_q.push_back(d);
      m_phase = 0;
      m_pcnt  = 0;
      case (d)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_x = m_xs; m_y = m_ys; end
        8'h01: begin model_defaults(); m_mode = 0; end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_pb[m_pcnt] = d;
      m_pcnt++;
      if (m_pcnt == 4) begin
        if (m_mode == 1) begin m_xs = {m_pb[0], m_pb[1]}; m_xe = {m_pb[2], m_pb[3]}; end
        else             begin m_ys = {m_pb[0], m_pb[1]}; m_ye = {m_pb[2], m_pb[3]}; end
        m_mode = 0;
        m_pcnt = 0;
      end
    end else if (m_mode == 3) begin
      if (m_phase == 0) begin
        m_hi = d;
        m_phase = 1;
      end else begin
        m_phase = 0;
        if (m_drop_next) begin
          m_drop_next = 1'b0;
        end else begin
          b.d = {m_hi, d};
          b.x = m_x;
          b.y = m_y;
          b.u = (m_x == m_xs) && (m_y == m_ys);
          b.l = (m_x == m_xe) && (m_y == m_ye);
          exp_q.push_back(b);
        end
        if (m_x >= m_xe) begin
          m_x = m_xs;
          m_y = (m_y >= m_ye) ? m_ys : m_y + 16'd1;
        end else begin
          m_x = m_x + 16'd1;
        end
      end
    end
  endfunction

  task automatic send(input bit dc, input logic [7:0] d);
    model_byte(dc, d);
    @(posedge aclk); #1;
    bus.cs = 1'b0; bus.dc = dc; bus.data = d; bus.wr = 1'b0;
    repeat ($urandom_range(1, 2)) @(posedge aclk);
    #1 bus.wr = 1'b1;
    repeat ($urandom_range(1, 2)) @(posedge aclk);
  endtask

  task automatic cmd(input logic [7:0] d);
    send(1'b0, d);
  endtask

  task automatic par(input logic [7:0] d);
    send(1'b1, d);
  endtask

  task automatic pixel(input logic [15:0] v);
    par(v[15:8]);
    par(v[7:0]);
  endtask

  task automatic window(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    cmd(c); par(s[15:8]); par(s[7:0]); par(e[15:8]); par(e[7:0]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    check("drain_pending_pixels", exp_q.size(), 0);
    repeat (6) @(posedge aclk);
  endtask

  // Downstream ready: random, but never stalls long enough to lose a pixel unless held.
  always @(posedge aclk) begin
    #1;
    if (hold_ready)         bus.m_axis_tready = 1'b0;
    else if (stall_cnt >= 2) bus.m_axis_tready = 1'b1;
    else                    bus.m_axis_tready = ($urandom_range(0, 3) != 0);
  end

  beat_t prev_b;
  bit    prev_stall = 1'b0;

  always @(negedge aclk) begin
    beat_t a, e;
    if (reset) begin
      prev_stall = 1'b0;
      stall_cnt  = 0;
    end else begin
      a.d = bus.m_axis_tdata; a.x = bus.pixel_x; a.y = bus.pixel_y;
      a.u = bus.m_axis_tuser; a.l = bus.m_axis_tlast;
      if (prev_stall && bus.m_axis_tvalid)
        check("stable_while_stalled", a, prev_b);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat_tdata", a.d, 16'hxxxx);
        end else begin
          e = exp_q.pop_front();
          check("tdata", a.d, e.d);
          check("pixel_x", a.x, e.x);
          check("pixel_y", a.y, e.y);
          check("tuser", a.u, e.u);
          check("tlast", a.l, e.l);
        end
        got_q.push_back(a);
      end
      if (bus.cmd_strobe) begin
        if (cmd_q.size() == 0) check("unexpected_cmd_strobe", bus.cmd_code, 8'hxx);
        else                   check("cmd_code", bus.cmd_code, cmd_q.pop_front());
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_b     = a;
      stall_cnt  = prev_stall ? stall_cnt + 1 : 0;
    end
  end

  initial begin
    int tl_cnt;
    int r, n;
    logic [15:0] s, e;
    int xs_exp[5] = '{10, 11, 10, 11, 10};
    int ys_exp[5] = '{5, 5, 6, 6, 5};

    reset = 1'b1;
    bus.cs = 1'b1; bus.wr = 1'b1; bus.dc = 1'b1; bus.data = 8'h00;
    bus.rd = 1'b1; bus.rst = 1'b1; bus.m_axis_tready = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    check("reset_tvalid", bus.m_axis_tvalid, 0);
    check("reset_tdata", bus.m_axis_tdata, 0);
    check("reset_xy", {bus.pixel_x, bus.pixel_y}, 0);
    check("reset_tuser_tlast", {bus.m_axis_tuser, bus.m_axis_tlast}, 0);
    check("reset_cmd", {bus.cmd_strobe, bus.cmd_code}, 0);
    check("reset_overflow", bus.overflow, 0);
    reset = 1'b0;
    repeat (3) @(posedge aclk);

    // Init then pixels, with the output latency measured on the final byte.
    got_q.delete();
    cmd(8'h2C);
    pixel(16'hF800);
    drain();
    hold_ready = 1'b1;
    repeat (3) @(posedge aclk);
    par(8'h07);
    model_byte(1'b1, 8'hE0);
    @(posedge aclk); #1 bus.data = 8'hE0; bus.wr = 1'b0;
    @(posedge aclk); #1 bus.wr = 1'b1;
    repeat (2) @(posedge aclk);
    #1 check("latency_not_early", bus.m_axis_tvalid, 0);
    @(posedge aclk);
    #1 check("latency_sync_plus_1", bus.m_axis_tvalid, 1);
    hold_ready = 1'b0;
    drain();
    check("t1_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t1_beat0", got_q[0], {16'hF800, 16'd0, 16'd0, 1'b1, 1'b0});
      check("t1_beat1", got_q[1], {16'h07E0, 16'd1, 16'd0, 1'b0, 1'b0});
    end

    // Small window with wrap back to the origin.
    got_q.delete();
    window(8'h2A, 16'd10, 16'd11);
    window(8'h2B, 16'd5, 16'd6);
    cmd(8'h2C);
    for (int i = 0; i < 5; i++) pixel(16'($urandom));
    drain();
    check("t2_count", got_q.size(), 5);
    if (got_q.size() == 5)
      for (int i = 0; i < 5; i++) begin
        check("t2_x", got_q[i].x, xs_exp[i]);
        check("t2_y", got_q[i].y, ys_exp[i]);
        check("t2_tlast", got_q[i].l, (i == 3));
        check("t2_tuser", got_q[i].u, (i == 0 || i == 4));
      end

    // Default 320-column width, last two pages, through the frame end and wrap.
    got_q.delete();
    cmd(8'h01);
    window(8'h2B, 16'd238, 16'd239);
    cmd(8'h2C);
    for (int i = 0; i < 641; i++) pixel(16'($urandom));
    drain();
    check("t3_count", got_q.size(), 641);
    if (got_q.size() == 641) begin
      tl_cnt = 0;
      foreach (got_q[i]) if (got_q[i].l) tl_cnt++;
      check("t3_tlast_count", tl_cnt, 1);
      check("t3_last_pixel", {got_q[639].x, got_q[639].y, got_q[639].l}, {16'd319, 16'd239, 1'b1});
      check("t3_row_wrap", {got_q[320].x, got_q[320].y}, {16'd0, 16'd239});
      check("t3_frame_wrap", {got_q[640].x, got_q[640].y, got_q[640].u}, {16'd0, 16'd238, 1'b1});
    end

    // Abort a partial pixel with a command.
    got_q.delete();
    cmd(8'h2C);
    par(8'hAB);
    cmd(8'h29);
    par(8'hCD);
    drain();
    check("t4_no_pixel", got_q.size(), 0);
    check("t4_cmd_code", bus.cmd_code, 8'h29);
    check("t4_strobes_seen", cmd_q.size(), 0);

    // Overflow under held backpressure.
    got_q.delete();
    cmd(8'h01);
    hold_ready = 1'b1;
    cmd(8'h2C);
    pixel(16'h1234);
    m_drop_next = 1'b1;
    pixel(16'h5678);
    repeat (5) @(posedge aclk);
    #1;
    check("t5_held_valid", bus.m_axis_tvalid, 1);
    check("t5_held_data", {bus.m_axis_tdata, bus.pixel_x}, {16'h1234, 16'd0});
    check("t5_overflow", bus.overflow, 1);
    hold_ready = 1'b0;
    drain();
    pixel(16'h9ABC);
    drain();
    check("t5_count", got_q.size(), 2);
    if (got_q.size() == 2) check("t5_after_drop_x", got_q[1].x, 16'd2);
    check("t5_overflow_sticky", bus.overflow, 1);

    // cs high gates wr edges.
    bus.cs = 1'b1; bus.dc = 1'b0; bus.data = 8'h2A;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1 bus.wr = 1'b0;
      repeat (2) @(posedge aclk); #1 bus.wr = 1'b1;
      repeat (2) @(posedge aclk);
    end
    #1 check("t6_cs_gated_code", bus.cmd_code, 8'h2C);
    pixel(16'h4242);
    drain();
    check("t6_still_in_ramwr", got_q.size(), 3);

    // Display reset pulse restores the default window but keeps overflow.
    got_q.delete();
    window(8'h2A, 16'h0010, 16'h0020);
    @(posedge aclk); #1 bus.rst = 1'b0;
    repeat (4) @(posedge aclk);
    model_reset();
    #1 bus.rst = 1'b1;
    repeat (4) @(posedge aclk);
    cmd(8'h2C);
    pixel(16'h1111);
    pixel(16'h2222);
    drain();
    check("t7_count", got_q.size(), 2);
    if (got_q.size() == 2)
      check("t7_default_xs", {got_q[0].x, got_q[1].x}, {16'd0, 16'd1});
    check("t7_overflow_held", bus.overflow, 1);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 6);
      case (r)
        0, 1: begin
          s = 16'($urandom_range(0, 12));
          e = 16'($urandom_range(0, 12));
          window((r == 0) ? 8'h2A : 8'h2B, s, e);
          if ($urandom_range(0, 3) == 0) par(8'($urandom));
        end
        2, 3: begin
          cmd(8'h2C);
          n = $urandom_range(1, 10);
          for (int k = 0; k < n; k++) pixel(16'($urandom));
          if ($urandom_range(0, 3) == 0) par(8'($urandom));
        end
        4: begin
          cmd(8'h29 + 8'($urandom_range(0, 1)) * 8'h0D);
          par(8'($urandom));
        end
        5: par(8'($urandom));
        default: if ($urandom_range(0, 3) == 0) cmd(8'h01); else cmd(8'h11);
      endcase
    end
    drain();

    // Asynchronous reset in the middle of a pixel.
    cmd(8'h2C);
    par(8'h55);
    drain();
    got_q.delete();
    @(posedge aclk); #1 reset = 1'b1;
    #1;
    check("t9_reset_out", {bus.m_axis_tvalid, bus.overflow, bus.cmd_code}, 0);
    model_reset();
    cmd_q.delete();
    repeat (2) @(posedge aclk);
    #1 reset = 1'b0;
    par(8'h11);
    par(8'h22);
    drain();
    check("t9_no_pixel_after_reset", got_q.size(), 0);
    check("t9_overflow_cleared", bus.overflow, 0);

    check("final_cmds_consumed", cmd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
